hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 34 +++
 rtl/hz_regdecode.sv | 58 +++++
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller: instruction class codes,
// next-PC source encodings, statistics counter width and a saturating increment.
package hazard_ctrl_pkg;

  typedef enum logic [7:0] {
    CLS_NOP  = 8'd0,
    CLS_ADD  = 8'd1,
    CLS_SUB  = 8'd2,
    CLS_AND  = 8'd3,
    CLS_OR   = 8'd4,
    CLS_SLL  = 8'd5,
    CLS_SRL  = 8'd6,
    CLS_SRA  = 8'd7,
    CLS_ADDI = 8'd8,
    CLS_ANDI = 8'd9,
    CLS_ORI  = 8'd10,
    CLS_LW   = 8'd11,
    CLS_SW   = 8'd12,
    CLS_BEQ  = 8'd13,
    CLS_BNE  = 8'd14,
    CLS_J    = 8'd15
  } cls_e;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hz_regdecode.sv
// Combinational source/destination register extraction driven by the class code.
// Register 0 is never reported as a source or a destination.
module hz_regdecode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [7:0]  instr_type,
  output logic        rs_use,
  output logic        rt_use,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic        dest_valid,
  output logic [4:0]  dest
);

  logic rs_rd;
  logic rt_rd;
  logic wr_rd;
  logic wr_rt;
  logic unused_bits;

  assign unused_bits = ^{instr[31:26], instr[10:0]};

  always_comb begin
    rs_rd = 1'b0;
    rt_rd = 1'b0;
    wr_rd = 1'b0;
    wr_rt = 1'b0;
    case (instr_type)
      CLS_ADD, CLS_SUB, CLS_AND, CLS_OR: begin
        rs_rd = 1'b1;
        rt_rd = 1'b1;
        wr_rd = 1'b1;
      end
      CLS_SLL, CLS_SRL, CLS_SRA: begin
        rt_rd = 1'b1;
        wr_rd = 1'b1;
      end
      CLS_ADDI, CLS_ANDI, CLS_ORI, CLS_LW: begin
        rs_rd = 1'b1;
        wr_rt = 1'b1;
      end
      CLS_SW, CLS_BEQ, CLS_BNE: begin
        rs_rd = 1'b1;
        rt_rd = 1'b1;
      end
      default: ;
    endcase
  end

  assign rs         = instr[25:21];
  assign rt         = instr[20:16];
  assign rs_use     = rs_rd && (rs != 5'd0);
  assign rt_use     = rt_rd && (rt != 5'd0);
  assign dest       = wr_rd ? instr[15:11] : instr[20:16];
  assign dest_valid = (wr_rd || wr_rt) && (dest != 5'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use/RAW interlock for a forwarding-free pipeline: tracks EX/MEM destinations,
// stalls dependent ID instructions, and steers PC/flushes for taken branches and jumps.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic             CCLK,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [7:0]       id_type,
  input  logic             br_taken,
  output logic             stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       pc_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             rs_use, rt_use, dest_valid;
  logic [4:0]       rs, rt, dest;
  logic             ex_valid_q, ex_valid_d, mem_valid_q, mem_valid_d;
  logic [4:0]       ex_dest_q, ex_dest_d, mem_dest_q, mem_dest_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             hz_rs, hz_rt, hazard, advance;

  hz_regdecode u_id_decode (
    .instr      (id_instr),
    .instr_type (id_type),
    .rs_use     (rs_use),
    .rt_use     (rt_use),
    .rs         (rs),
    .rt         (rt),
    .dest_valid (dest_valid),
    .dest       (dest)
  );

  // WB writes before the register file is read, so only EX and MEM producers block.
  assign hz_rs  = rs_use && ((ex_valid_q && ex_dest_q == rs) || (mem_valid_q && mem_dest_q == rs));
  assign hz_rt  = rt_use && ((ex_valid_q && ex_dest_q == rt) || (mem_valid_q && mem_dest_q == rt));
  assign hazard = id_valid && (hz_rs || hz_rt);

  always_comb begin
    stall      = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    pc_sel     = PC_SEQ;
    advance    = 1'b0;
    if (rst) begin
      if (br_taken) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        pc_sel     = PC_BRANCH;
      end else begin
        stall      = hazard;
        flush_idex = hazard;
        if (id_valid && !hazard) begin
          advance = 1'b1;
          if (id_type == CLS_J) begin
            pc_sel     = PC_JUMP;
            flush_ifid = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    ex_valid_d  = advance && dest_valid;
    ex_dest_d   = dest;
    mem_valid_d = ex_valid_q;
    mem_dest_d  = ex_dest_q;
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = flush_ifid ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  always_ff @(posedge CCLK or negedge rst) begin
    if (!rst) begin
      ex_valid_q  <= 1'b0;
      ex_dest_q   <= 5'd0;
      mem_valid_q <= 1'b0;
      mem_dest_q  <= 5'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_dest_q   <= ex_dest_d;
      mem_valid_q <= mem_valid_d;
      mem_dest_q  <= mem_dest_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an in-flight-writer model.
module tb_hazard_ctrl;

  logic        CCLK = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = 32'd0;
  logic [7:0]  id_type = 8'd0;
  logic        br_taken = 1'b0;
  logic        stall, flush_ifid, flush_idex;
  logic [1:0]  pc_sel;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .CCLK       (CCLK),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_type    (id_type),
    .br_taken   (br_taken),
    .stall      (stall),
    .flush_ifid (flush_ifid),
    .flush_idex (flush_idex),
    .pc_sel     (pc_sel),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 CCLK = ~CCLK;

  // ---------------- reference model ----------------
  // inflight[0] = register written by the instruction one ahead, inflight[1] = two ahead; 0 = none.
  int inflight [2];
  int m_sc, m_fc;

  function automatic int m_dest(logic [31:0] ins, int t);
    if (t >= 1 && t <= 7)  return int'(ins[15:11]);
    if (t >= 8 && t <= 11) return int'(ins[20:16]);
    return 0;
  endfunction

  function automatic bit m_reads(logic [31:0] ins, int t, int r);
    bit urs, urt;
    if (r == 0) return 1'b0;
    urs = (t >= 1 && t <= 4) || (t >= 8 && t <= 14);
    urt = (t >= 1 && t <= 7) || (t >= 12 && t <= 14);
    return (urs && int'(ins[25:21]) == r) || (urt && int'(ins[20:16]) == r);
  endfunction

  // {stall, flush_ifid, flush_idex, pc_sel}
  function automatic logic [4:0] m_ctrl();
    bit hz;
    int t;
    t  = int'(id_type);
    hz = id_valid && (m_reads(id_instr, t, inflight[0]) || m_reads(id_instr, t, inflight[1]));
    if (!rst)     return 5'b0_0_0_00;
    if (br_taken) return 5'b0_1_1_01;
    if (hz)       return 5'b1_0_1_00;
    if (id_valid && t == 15) return 5'b0_1_0_10;
    return 5'b0_0_0_00;
  endfunction

  always @(posedge CCLK or negedge rst) begin
    logic [4:0] c;
    if (!rst) begin
      inflight[0] <= 0;
      inflight[1] <= 0;
      m_sc <= 0;
      m_fc <= 0;
    end else begin
      c = m_ctrl();
      inflight[1] <= inflight[0];
      inflight[0] <= (id_valid && !br_taken && !c[4]) ? m_dest(id_instr, int'(id_type)) : 0;
      if (c[4] && m_sc < 65535) m_sc <= m_sc + 1;
      if (c[3] && m_fc < 65535) m_fc <= m_fc + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge CCLK) begin
    logic [36:0] got, exp;
    got = {stall, flush_ifid, flush_idex, pc_sel, stall_cnt, flush_cnt};
    exp = {m_ctrl(), m_sc[15:0], m_fc[15:0]};
    chk("cycle_model", 64'(got), 64'(exp));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [31:0] ins, input logic [7:0] t, input bit br);
    @(posedge CCLK);
    #1;
    id_valid = v;
    id_instr = ins;
    id_type  = t;
    br_taken = br;
  endtask

  task automatic reset_dut();
    @(posedge CCLK);
    #1;
    rst = 1'b0;
    id_valid = 1'b0; id_instr = 32'd0; id_type = 8'd0; br_taken = 1'b0;
    repeat (2) @(posedge CCLK);
    #1;
    rst = 1'b1;
  endtask

  localparam logic [31:0] ADD3 = 32'h00221820;
  localparam logic [31:0] SUB5 = 32'h00642822;

  initial begin
    logic [31:0] ins;
    @(negedge CCLK);
    chk("reset_outputs", 64'({stall, flush_ifid, flush_idex, pc_sel, stall_cnt, flush_cnt}), 64'd0);
    reset_dut();

    // back-to-back RAW: two stall cycles
    drive(1, ADD3, 8'd1, 0); @(negedge CCLK); chk("raw1_add_nostall", 64'(stall), 64'd0);
    drive(1, SUB5, 8'd2, 0); @(negedge CCLK); chk("raw1_stall_a", 64'({stall, flush_idex}), 64'd3);
    drive(1, SUB5, 8'd2, 0); @(negedge CCLK); chk("raw1_stall_b", 64'({stall, flush_idex}), 64'd3);
    drive(1, SUB5, 8'd2, 0); @(negedge CCLK); chk("raw1_release", 64'(stall), 64'd0);
    chk("raw1_stall_cnt", 64'(stall_cnt), 64'd2);

    // RAW two ahead: one stall cycle
    reset_dut();
    drive(1, 32'h8C080000, 8'd11, 0);
    drive(1, 32'h00000000, 8'd0, 0);
    drive(1, 32'h21090001, 8'd8, 0);  @(negedge CCLK); chk("raw2_stall", 64'(stall), 64'd1);
    drive(1, 32'h21090001, 8'd8, 0);  @(negedge CCLK); chk("raw2_release", 64'(stall), 64'd0);
    chk("raw2_stall_cnt", 64'(stall_cnt), 64'd1);

    // $0 never creates a dependence
    reset_dut();
    drive(1, 32'h20200005, 8'd8, 0); @(negedge CCLK); chk("zero_a", 64'(stall), 64'd0);
    drive(1, 32'h00021820, 8'd1, 0); @(negedge CCLK); chk("zero_b", 64'(stall), 64'd0);
    drive(1, 32'h00021820, 8'd1, 0); @(negedge CCLK); chk("zero_cnt", 64'(stall_cnt), 64'd0);

    // jump
    reset_dut();
    drive(1, 32'h08000000, 8'd15, 0); @(negedge CCLK);
    chk("jump_ctrl", 64'({pc_sel, flush_ifid, flush_idex}), 64'b10_1_0);
    drive(0, 32'h0, 8'd0, 0); @(negedge CCLK);
    chk("jump_done", 64'({pc_sel, flush_ifid}), 64'd0);
    chk("jump_flush_cnt", 64'(flush_cnt), 64'd1);

    // taken branch beats a pending hazard and bubbles EX
    reset_dut();
    drive(1, ADD3, 8'd1, 0);
    drive(1, SUB5, 8'd2, 1); @(negedge CCLK);
    chk("br_prio", 64'({stall, flush_ifid, flush_idex, pc_sel}), 64'b0_1_1_01);
    drive(1, SUB5, 8'd2, 0); @(negedge CCLK); chk("br_mem_stall", 64'(stall), 64'd1);
    drive(1, SUB5, 8'd2, 0); @(negedge CCLK); chk("br_clear", 64'(stall), 64'd0);

    // reset during the second stall cycle
    reset_dut();
    drive(1, ADD3, 8'd1, 0);
    drive(1, SUB5, 8'd2, 0); @(negedge CCLK); chk("rst_pre_stall", 64'(stall), 64'd1);
    drive(1, SUB5, 8'd2, 0);
    #2 rst = 1'b0;
    #1 chk("rst_async_outputs", 64'({stall, flush_ifid, flush_idex, pc_sel, stall_cnt}), 64'd0);
    @(posedge CCLK); #1 rst = 1'b1;
    @(negedge CCLK); chk("rst_release_nostall", 64'(stall), 64'd0);

    // randomized traffic over a small register pool to create frequent dependences
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      ins = {6'($urandom_range(0, 63)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 11'($urandom)};
      drive($urandom_range(0, 4) != 0, ins, 8'($urandom_range(0, 19)), $urandom_range(0, 7) == 0);
    end

    // flush counter saturation under a continuous taken-branch stream
    reset_dut();
    drive(0, 32'h0, 8'd0, 1);
    repeat (65540) @(posedge CCLK);
    @(negedge CCLK); chk("flush_cnt_sat", 64'(flush_cnt), 64'hFFFF);
    drive(0, 32'h0, 8'd0, 0);
    @(negedge CCLK); chk("flush_cnt_hold", 64'(flush_cnt), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
